// File: rtl/io_controller.sv
// Processor I/O block: IN reads a switch-derived value after a debounced
// confirm press (stalling the core meanwhile); OUT writes 32-bit display channels.
module io_controller #(
    parameter int IN_W       = 16,
    parameter int OUT_CH     = 2,
    parameter int DEB_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [IN_W-1:0]        inputs,
    input  logic                   enter,
    input  logic [31:0]            data,
    input  logic [5:0]             funct,
    input  logic                   op_in,
    input  logic                   op_out,
    output logic [31:0]            entrada,
    output logic                   in_valid,
    output logic                   halt,
    output logic [OUT_CH*32-1:0]   saida
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_REL, WAIT_PRESS, DONE} state_t;

    state_t          state, next_state;
    logic [IN_W-1:0] sw_m, sw_s;
    logic            en_m, en_s, en_db, en_db_q, press, load;
    logic [CW-1:0]   deb_cnt;
    logic [31:0]     sw_ext, rd_val;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_m <= '0;
            sw_s <= '0;
            en_m <= 1'b0;
            en_s <= 1'b0;
        end else begin
            sw_m <= inputs;
            sw_s <= sw_m;
            en_m <= enter;
            en_s <= en_m;
        end
    end

    // Counter restarts whenever the synchronised level agrees with the
    // debounced one, and is cleared on the flip, so it can never wrap.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            en_db   <= 1'b0;
            en_db_q <= 1'b0;
            deb_cnt <= '0;
        end else begin
            en_db_q <= en_db;
            if (en_s == en_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
                en_db   <= en_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press  = en_db & ~en_db_q;
    assign sw_ext = 32'(sw_s);

    always_comb begin
        rd_val = '0;
        if (funct < 6'(IN_W)) begin
            rd_val = {31'b0, sw_ext[funct[4:0]]};
        end else if (funct == 6'd22) begin
            rd_val = {24'b0, sw_ext[7:0]};
        end else if (funct == 6'd23) begin
            rd_val = sw_ext;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        in_valid   = 1'b0;
        halt       = 1'b0;
        case (state)
            IDLE: begin
                halt = op_in;
                if (op_in) begin
                    next_state = en_db ? WAIT_REL : WAIT_PRESS;
                end
            end
            WAIT_REL: begin
                halt = 1'b1;
                if (!en_db) begin
                    next_state = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                halt = 1'b1;
                if (press) begin
                    load       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                in_valid   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (!resetn) begin
            halt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            entrada <= '0;
        end else if (load) begin
            entrada <= rd_val;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            saida <= '0;
        end else if (op_out) begin
            for (int unsigned k = 0; k < OUT_CH; k++) begin
                if (funct == 6'(k)) begin
                    saida[32*k +: 32] <= data;
                end
            end
        end
    end
endmodule

// File: tb/tb_io_controller.sv
// Scoreboard bench for io_controller: reads are predicted from the switch
// value at press time; writes are tracked in a channel array model.
module tb_io_controller;
    localparam int IN_W   = 16;
    localparam int OUT_CH = 2;
    localparam int DEB    = 4;
    localparam int LAT    = 6;  // negedges from enter rise until DONE is visible

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic [IN_W-1:0]      inputs = '0;
    logic                 enter = 1'b0;
    logic [31:0]          data = '0;
    logic [5:0]           funct = '0;
    logic                 op_in = 1'b0;
    logic                 op_out = 1'b0;
    logic [31:0]          entrada;
    logic                 in_valid;
    logic                 halt;
    logic [OUT_CH*32-1:0] saida;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_ch[OUT_CH];
    logic        prev_v = 1'b0;

    always #5 clock = ~clock;

    io_controller #(.IN_W(IN_W), .OUT_CH(OUT_CH), .DEB_CYCLES(DEB)) dut (
        .clock(clock), .resetn(resetn), .inputs(inputs), .enter(enter),
        .data(data), .funct(funct), .op_in(op_in), .op_out(op_out),
        .entrada(entrada), .in_valid(in_valid), .halt(halt), .saida(saida)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [IN_W-1:0] sw, input int f);
        if (f < IN_W) return 32'((sw >> f) & 1);
        if (f == 22)  return 32'(sw & 16'h00FF);
        if (f == 23)  return 32'(sw);
        return 32'd0;
    endfunction

    function automatic logic [OUT_CH*32-1:0] model_saida();
        logic [OUT_CH*32-1:0] r;
        for (int k = 0; k < OUT_CH; k++) r[32*k +: 32] = exp_ch[k];
        return r;
    endfunction

    // Monitor: every in_valid pulse consumes one predicted read.
    always @(negedge clock) begin
        if (resetn && in_valid) begin
            chk("halt_in_done", 64'(halt), 64'd0);
            chk("in_valid_single", 64'(prev_v), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: got entrada=%0h expected no read", entrada);
            end else begin
                chk("entrada", 64'(entrada), 64'(exp_q.pop_front()));
            end
        end
        prev_v <= resetn && in_valid;
    end

    task automatic begin_read(input int f, input logic [IN_W-1:0] sw);
        @(negedge clock);
        funct  = 6'(f);
        inputs = sw;
        op_in  = 1'b1;
    endtask

    task automatic finish_read(input bit bounce);
        bit got = 0;
        int lat = 0;
        repeat (2) @(negedge clock);
        if (bounce) begin
            for (int b = 0; b < 3; b++) begin
                enter = 1'b1;
                repeat (3) @(negedge clock);
                enter = 1'b0;
                repeat (3) @(negedge clock);
            end
            chk("halt_after_bounce", 64'(halt), 64'd1);
        end
        exp_q.push_back(model_read(inputs, int'(funct)));
        enter = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (!halt) begin
                got = 1;
                lat = i;
            end
        end
        if (got) begin
            chk("press_latency", 64'(lat), 64'(LAT));
        end else begin
            checks++;
            failures++;
            $display("FAIL read_timeout: got halt=1 after 40 cycles expected halt=0");
        end
        op_in = 1'b0;
        repeat (2) @(negedge clock);
        enter = 1'b0;
        repeat (12) @(negedge clock);
        chk("halt_idle", 64'(halt), 64'd0);
    endtask

    task automatic do_write(input int f, input logic [31:0] d);
        logic [5:0] saved = funct;
        @(negedge clock);
        op_out = 1'b1;
        funct  = 6'(f);
        data   = d;
        @(negedge clock);
        op_out = 1'b0;
        funct  = saved;
        if (f < OUT_CH) exp_ch[f] = d;
        chk("saida", 64'(saida), 64'(model_saida()));
    endtask

    initial begin
        for (int k = 0; k < OUT_CH; k++) exp_ch[k] = '0;

        // Reset with a pending request and a chattering button.
        op_in  = 1'b1;
        inputs = 16'hA5C3;
        funct  = 6'd5;
        for (int i = 0; i < 6; i++) begin
            enter = ~enter;
            @(negedge clock);
            chk("rst_entrada", 64'(entrada), 64'd0);
            chk("rst_outputs", {62'(saida), in_valid, halt}, 64'd0);
        end
        enter  = 1'b0;
        resetn = 1'b1;
        #1 chk("halt_after_release", 64'(halt), 64'd1);
        @(negedge clock);
        chk("halt_wait_press", 64'(halt), 64'd1);
        finish_read(0);

        begin_read(0, 16'hA5C3);  finish_read(0);
        begin_read(22, 16'hBEEF); finish_read(0);
        begin_read(23, 16'hBEEF); finish_read(0);
        begin_read(30, 16'hBEEF); finish_read(0);
        begin_read(23, 16'h1234); finish_read(1);

        // Button already held at request time; switches change before the real press.
        enter = 1'b1;
        repeat (10) @(negedge clock);
        begin_read(23, 16'h1111);
        repeat (10) @(negedge clock);
        chk("halt_held", 64'(halt), 64'd1);
        inputs = 16'h2222;
        repeat (3) @(negedge clock);
        enter = 1'b0;
        repeat (10) @(negedge clock);
        chk("halt_released", 64'(halt), 64'd1);
        finish_read(0);

        do_write(1, 32'h12345678);
        do_write(0, 32'hCAFEBABE);
        do_write(3, 32'hDEADBEEF);
        do_write(2, 32'h0BADF00D);

        // Write landing while a read is stalled.
        begin_read(1, 16'h0002);
        repeat (2) @(negedge clock);
        do_write(1, 32'h55AA55AA);
        chk("halt_during_write", 64'(halt), 64'd1);
        finish_read(0);

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_write(int'($urandom_range(0, 3)), $urandom);
            begin_read(int'($urandom_range(0, 31)), IN_W'($urandom));
            finish_read(bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a read.
        begin_read(23, 16'hBEEF); finish_read(0);
        begin_read(23, 16'hFFFF);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        #1;
        for (int k = 0; k < OUT_CH; k++) exp_ch[k] = '0;
        chk("midrst_entrada", 64'(entrada), 64'd0);
        chk("midrst_halt", 64'(halt), 64'd0);
        chk("midrst_saida", 64'(saida), 64'(model_saida()));
        op_in = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        begin_read(22, 16'h00C7); finish_read(0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
